// File: rtl/sent_tx_pkg.sv
// Shared definitions for the SENT transmitter CRC engine: mode and done
// encodings, CRC polynomials and seeds, message sizing helpers and FSM states.
package sent_tx_pkg;

  // enable_crc_gen mode encodings
  localparam logic [2:0] MODE_FC6  = 3'b001;  // 6 nibbles, CRC4
  localparam logic [2:0] MODE_FC4  = 3'b010;  // 4 nibbles, CRC4
  localparam logic [2:0] MODE_FC3  = 3'b011;  // 3 nibbles, CRC4
  localparam logic [2:0] MODE_SER3 = 3'b100;  // 3 nibbles, CRC4 (serial)
  localparam logic [2:0] MODE_ESM  = 3'b101;  // 24 bits, CRC6

  // crc_gen_done codes
  localparam logic [1:0] DONE_NONE = 2'b00;
  localparam logic [1:0] DONE_FC   = 2'b01;
  localparam logic [1:0] DONE_SER  = 2'b10;
  localparam logic [1:0] DONE_ESM  = 2'b11;

  // Polynomial low bits (implicit leading one) and seeds
  localparam logic [3:0] CRC4_POLY = 4'b1101;    // x^4+x^3+x^2+1
  localparam logic [3:0] CRC4_SEED = 4'b0101;
  localparam logic [5:0] CRC6_POLY = 6'b011001;  // x^6+x^4+x^3+1
  localparam logic [5:0] CRC6_SEED = 6'b010101;

  // Longest message (24 data bits plus 6 augmentation zeros)
  localparam int MSG_W = 30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic mode_is_legal(input logic [2:0] mode);
    return (mode == MODE_FC6) || (mode == MODE_FC4) || (mode == MODE_FC3) ||
           (mode == MODE_SER3) || (mode == MODE_ESM);
  endfunction

  // Number of data bits N carried by a mode
  function automatic logic [5:0] mode_data_bits(input logic [2:0] mode);
    case (mode)
      MODE_FC6, MODE_ESM: return 6'd24;
      MODE_FC4:           return 6'd16;
      default:            return 6'd12;
    endcase
  endfunction

  function automatic logic [1:0] mode_done_code(input logic [2:0] mode);
    case (mode)
      MODE_SER3: return DONE_SER;
      MODE_ESM:  return DONE_ESM;
      default:   return DONE_FC;
    endcase
  endfunction

endpackage

// File: rtl/sent_tx_crc_step.sv
// Combinational CRC advance: clocks up to MAX_BITS message bits (MSB first)
// through a 4-bit or 6-bit CRC register in one evaluation.
module sent_tx_crc_step
  import sent_tx_pkg::*;
#(
  parameter int MAX_BITS = 4
) (
  input  logic [5:0]          r_i,
  input  logic [MAX_BITS-1:0] bits_i,
  input  logic [2:0]          cnt_i,
  input  logic                crc6_i,
  output logic [5:0]          r_o
);

  // Unrolled bit-serial division; bits beyond cnt_i leave the register alone
  always_comb begin
    r_o = r_i;
    for (int i = 0; i < MAX_BITS; i++) begin
      if (3'(i) < cnt_i) begin
        if (crc6_i) begin
          r_o = {r_o[4:0], bits_i[MAX_BITS-1-i]} ^ (r_o[5] ? CRC6_POLY : 6'd0);
        end else begin
          r_o = {2'b00, r_o[2:0], bits_i[MAX_BITS-1-i]} ^
                (r_o[3] ? {2'b00, CRC4_POLY} : 6'd0);
        end
      end
    end
  end

endmodule

// File: rtl/sent_tx_crc_engine.sv
// SENT TX CRC engine: fast-channel CRC4 and enhanced-serial CRC6, computed
// BITS_PER_CYCLE bits per clock with a start/busy/done handshake.
// Optional build macro SENT_CRC_LEGACY_EN selects the non-augmented legacy
// CRC4 algorithm; CRC6 is unaffected.
module sent_tx_crc_engine
  import sent_tx_pkg::*;
#(
  parameter int MAX_DATA_BITS  = 24,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                     clk_tx,
  input  logic                     reset_tx,
  input  logic                     start_crc,
  input  logic [2:0]               enable_crc_gen,
  input  logic [MAX_DATA_BITS-1:0] data_gen_crc,
  output logic                     busy,
  output logic [5:0]               crc_gen,
  output logic [1:0]               crc_gen_done
);

  localparam logic [5:0] BPC_W = 6'(BITS_PER_CYCLE);
  localparam logic [2:0] BPC_N = 3'(BITS_PER_CYCLE);

  state_e           state_q, state_d;
  logic             crc6_q, crc6_d;
  logic [1:0]       code_q, code_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic [5:0]       rem_q, rem_d;
  logic [5:0]       r_q, r_d;
  logic             busy_q, busy_d;
  logic [5:0]       crc_q, crc_d;
  logic [1:0]       done_q, done_d;

  logic [2:0]       step_cnt;
  logic [5:0]       step_r;
  logic             start_crc6;
  logic [5:0]       start_len;
  logic [MSG_W-1:0] start_msg;

  // Bits consumed this cycle: a full group, or whatever is left
  always_comb begin
    if (rem_q < BPC_W) step_cnt = rem_q[2:0];
    else               step_cnt = BPC_N;
  end

  sent_tx_crc_step #(.MAX_BITS(4)) u_step (
    .r_i    (r_q),
    .bits_i (msg_q[MSG_W-1 -: 4]),
    .cnt_i  (step_cnt),
    .crc6_i (crc6_q),
    .r_o    (step_r)
  );

  // Request decode: CRC width, total bit count and left-aligned message
  always_comb begin
    start_crc6 = (enable_crc_gen == MODE_ESM);
`ifdef SENT_CRC_LEGACY_EN
    start_len = mode_data_bits(enable_crc_gen) + (start_crc6 ? 6'd6 : 6'd0);
`else
    start_len = mode_data_bits(enable_crc_gen) + (start_crc6 ? 6'd6 : 6'd4);
`endif
    // Trailing zeros double as the augmentation bits
    case (enable_crc_gen)
      MODE_FC6, MODE_ESM: start_msg = {data_gen_crc[23:0], 6'd0};
      MODE_FC4:           start_msg = {data_gen_crc[15:0], 14'd0};
      default:            start_msg = {data_gen_crc[11:0], 18'd0};
    endcase
  end

  // Next-state and output logic for IDLE -> SHIFT -> DONE
  always_comb begin
    state_d = state_q;
    crc6_d  = crc6_q;
    code_d  = code_q;
    msg_d   = msg_q;
    rem_d   = rem_q;
    r_d     = r_q;
    busy_d  = busy_q;
    crc_d   = crc_q;
    done_d  = DONE_NONE;
    case (state_q)
      IDLE: begin
        if (start_crc && mode_is_legal(enable_crc_gen)) begin
          state_d = SHIFT;
          busy_d  = 1'b1;
          crc6_d  = start_crc6;
          code_d  = mode_done_code(enable_crc_gen);
          msg_d   = start_msg;
          rem_d   = start_len;
          r_d     = start_crc6 ? CRC6_SEED : {2'b00, CRC4_SEED};
        end
      end
      SHIFT: begin
        r_d   = step_r;
        msg_d = msg_q << BITS_PER_CYCLE;
        rem_d = rem_q - {3'b000, step_cnt};
        if (rem_d == 6'd0) state_d = DONE;
      end
      DONE: begin
        crc_d   = r_q;
        done_d  = code_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously by reset
  always_ff @(posedge clk_tx or negedge reset_tx) begin
    if (!reset_tx) begin
      state_q <= IDLE;
      crc6_q  <= 1'b0;
      code_q  <= DONE_NONE;
      msg_q   <= '0;
      rem_q   <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      crc_q   <= '0;
      done_q  <= DONE_NONE;
    end else begin
      state_q <= state_d;
      crc6_q  <= crc6_d;
      code_q  <= code_d;
      msg_q   <= msg_d;
      rem_q   <= rem_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      crc_q   <= crc_d;
      done_q  <= done_d;
    end
  end

  assign busy         = busy_q;
  assign crc_gen      = crc_q;
  assign crc_gen_done = done_q;

endmodule

// File: tb/tb_sent_tx_crc_engine.sv
// Testbench for sent_tx_crc_engine: one instance at 1 bit/cycle and one at
// 4 bits/cycle, driven from a directed vector table plus hand sequences.
module tb_sent_tx_crc_engine;

  logic        clk_tx = 1'b0;
  logic        reset_tx = 1'b0;
  logic        start1 = 1'b0, start4 = 1'b0;
  logic [2:0]  mode_in = 3'b000;
  logic [23:0] data_in = 24'd0;
  logic        busy1, busy4;
  logic [5:0]  crc1, crc4;
  logic [1:0]  done1, done4;

  bit          sel = 1'b0;  // 0: 1-bit instance, 1: 4-bit instance
  logic        cur_busy;
  logic [5:0]  cur_crc;
  logic [1:0]  cur_done;

  int passed = 0;
  int total  = 0;
  bit legacy = 1'b0;

  always #5 clk_tx = ~clk_tx;

  sent_tx_crc_engine #(.MAX_DATA_BITS(24), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk_tx(clk_tx), .reset_tx(reset_tx), .start_crc(start1),
    .enable_crc_gen(mode_in), .data_gen_crc(data_in),
    .busy(busy1), .crc_gen(crc1), .crc_gen_done(done1));

  sent_tx_crc_engine #(.MAX_DATA_BITS(24), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk_tx(clk_tx), .reset_tx(reset_tx), .start_crc(start4),
    .enable_crc_gen(mode_in), .data_gen_crc(data_in),
    .busy(busy4), .crc_gen(crc4), .crc_gen_done(done4));

  always_comb begin
    cur_busy = sel ? busy4 : busy1;
    cur_crc  = sel ? crc4  : crc1;
    cur_done = sel ? done4 : done1;
  end

  typedef struct {
    logic [2:0]  mode;
    logic [23:0] data;
    logic [5:0]  crc;
    logic [1:0]  code;
    int          lat;   // edges from acceptance to done at 1 bit/cycle
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic int nbits(input logic [2:0] m);
    if (m == 3'b001 || m == 3'b101) return 24;
    if (m == 3'b010) return 16;
    return 12;
  endfunction

  function automatic logic [1:0] code_of(input logic [2:0] m);
    if (m == 3'b100) return 2'b10;
    if (m == 3'b101) return 2'b11;
    return 2'b01;
  endfunction

  // Reference: polynomial long division of {seed, data, zeros} by poly
  function automatic logic [5:0] model(input logic [2:0] m, input logic [23:0] d,
                                       input bit leg);
    int n, w, z;
    logic [63:0] v, p;
    n = nbits(m);
    w = (m == 3'b101) ? 6 : 4;
    z = (leg && w == 4) ? 0 : w;
    v = (w == 6) ? 64'h15 : 64'h5;
    p = (w == 6) ? 64'h59 : 64'h1D;
    v = (v << n) | ({40'd0, d} & ((64'd1 << n) - 64'd1));
    v = v << z;
    for (int i = n + z + w - 1; i >= w; i--)
      if (v[i]) v = v ^ (p << (i - w));
    return v[5:0];
  endfunction

  function automatic int total_bits(input logic [2:0] m, input bit leg);
    if (m == 3'b101) return nbits(m) + 6;
    return leg ? nbits(m) : nbits(m) + 4;
  endfunction

  task automatic launch(input logic [2:0] m, input logic [23:0] d);
    mode_in = m;
    data_in = d;
    if (sel) start4 = 1'b1; else start1 = 1'b1;
  endtask

  // Consume the acceptance edge, then follow the operation to its done pulse
  task automatic wait_result(input logic [5:0] ecrc, input logic [1:0] ecode,
                             input int elat, input bit inject, input string tag);
    int cyc;
    bit seen, busy_ok;
    @(posedge clk_tx); #1;
    start1 = 1'b0; start4 = 1'b0;
    cyc = 0; seen = 1'b0; busy_ok = 1'b1;
    while (!seen && cyc < 60) begin
      data_in = 24'($urandom);
      mode_in = 3'($urandom_range(0, 7));
      if (inject && cyc == 3) begin
        mode_in = 3'b101;
        if (sel) start4 = 1'b1; else start1 = 1'b1;
      end
      @(posedge clk_tx); #1;
      cyc++;
      start1 = 1'b0; start4 = 1'b0;
      if (cur_done != 2'b00) seen = 1'b1;
      else if (!cur_busy) busy_ok = 1'b0;
    end
    check({tag, " done_seen"}, int'(seen), 1);
    check({tag, " latency"}, cyc, elat);
    check({tag, " crc"}, int'(cur_crc), int'(ecrc));
    check({tag, " code"}, int'(cur_done), int'(ecode));
    check({tag, " busy_during"}, int'(busy_ok), 1);
    check({tag, " busy_at_done"}, int'(cur_busy), 0);
  endtask

  initial begin
    logic [5:0]  ecrc;
    logic [2:0]  m;
    logic [23:0] d;
    int          lat1, len, watch_done, watch_busy;
    logic [5:0]  held;

`ifdef SENT_CRC_LEGACY_EN
    legacy = 1'b1;
`endif

    vecs[0] = '{3'b011, 24'h000000, 6'h09, 2'b01, 17};
    vecs[1] = '{3'b010, 24'h000000, 6'h0C, 2'b01, 21};
    vecs[2] = '{3'b001, 24'h000000, 6'h05, 2'b01, 29};
    vecs[3] = '{3'b100, 24'h000000, 6'h09, 2'b10, 17};
    vecs[4] = '{3'b101, 24'h000000, 6'h26, 2'b11, 31};
    vecs[5] = '{3'b011, 24'h000001, 6'h04, 2'b01, 17};
    vecs[6] = '{3'b101, 24'h000001, 6'h3F, 2'b11, 31};
    vecs[7] = '{3'b010, 24'h008000, 6'h0B, 2'b01, 21};

    // Reset state
    repeat (2) @(posedge clk_tx);
    #1;
    check("reset busy1", int'(busy1), 0);
    check("reset crc1", int'(crc1), 0);
    check("reset done1", int'(done1), 0);
    check("reset busy4", int'(busy4), 0);
    check("reset crc4", int'(crc4), 0);
    check("reset done4", int'(done4), 0);
    reset_tx = 1'b1;
    @(posedge clk_tx); #1;

    // Directed table on both instances
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      for (int i = 0; i < 8; i++) begin
        ecrc = vecs[i].crc;
        lat1 = vecs[i].lat;
        if (legacy && vecs[i].mode != 3'b101) begin
          ecrc = model(vecs[i].mode, vecs[i].data, 1'b1);
          lat1 = nbits(vecs[i].mode) + 1;
        end
        len = lat1 - 1;
        launch(vecs[i].mode, vecs[i].data);
        wait_result(ecrc, vecs[i].code, sel ? (len + 3) / 4 + 1 : lat1, 1'b0,
                    $sformatf("vec%0d/bpc%0d", i, sel ? 4 : 1));
      end
    end

    // Done lasts one cycle and the result holds afterwards
    sel = 1'b0;
    launch(3'b011, 24'h000);
    wait_result(legacy ? model(3'b011, 24'h0, 1'b1) : 6'h09, 2'b01,
                legacy ? 13 : 17, 1'b0, "hold");
    held = crc1;
    repeat (3) begin
      @(posedge clk_tx); #1;
      check("done one cycle", int'(done1), 0);
      check("crc holds", int'(crc1), int'(held));
    end

    // Illegal modes are ignored
    for (int k = 0; k < 3; k++) begin
      m = (k == 0) ? 3'b110 : (k == 1) ? 3'b000 : 3'b111;
      launch(m, 24'hABCDEF);
      @(posedge clk_tx); #1;
      start1 = 1'b0;
      watch_done = 0; watch_busy = 0;
      repeat (20) begin
        @(posedge clk_tx); #1;
        if (done1 != 2'b00) watch_done++;
        if (busy1) watch_busy++;
      end
      check($sformatf("illegal %0b busy", m), watch_busy, 0);
      check($sformatf("illegal %0b done", m), watch_done, 0);
      check($sformatf("illegal %0b crc", m), int'(crc1), int'(held));
    end

    // Start while busy does not disturb the running operation
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      len = total_bits(3'b011, legacy);
      launch(3'b011, 24'h000);
      wait_result(model(3'b011, 24'h000, legacy), 2'b01,
                  sel ? (len + 3) / 4 + 1 : len + 1, 1'b1,
                  $sformatf("busy_start/bpc%0d", sel ? 4 : 1));
    end

    // Back-to-back: new start issued while done is showing
    sel = 1'b0;
    launch(3'b101, 24'h000000);
    wait_result(6'h26, 2'b11, 31, 1'b0, "b2b first");
    launch(3'b100, 24'h000);
    wait_result(legacy ? model(3'b100, 24'h0, 1'b1) : 6'h09, 2'b10,
                legacy ? 13 : 17, 1'b0, "b2b second");

    // Reset in the middle of SHIFT
    launch(3'b001, 24'h123456);
    @(posedge clk_tx); #1;
    start1 = 1'b0;
    repeat (5) @(posedge clk_tx);
    #1;
    check("pre-reset busy", int'(busy1), 1);
    reset_tx = 1'b0;
    #1;
    check("async reset busy", int'(busy1), 0);
    check("async reset crc", int'(crc1), 0);
    check("async reset done", int'(done1), 0);
    @(posedge clk_tx); #1;
    reset_tx = 1'b1;
    watch_done = 0; watch_busy = 0;
    repeat (35) begin
      @(posedge clk_tx); #1;
      if (done1 != 2'b00) watch_done++;
      if (busy1) watch_busy++;
    end
    check("post-reset no done", watch_done, 0);
    check("post-reset idle", watch_busy, 0);

    // Random data over all modes against the long-division model
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      for (int i = 0; i < 8; i++) begin
        m = 3'($urandom_range(1, 5));
        d = 24'($urandom);
        len = total_bits(m, legacy);
        launch(m, d);
        wait_result(model(m, d, legacy), code_of(m),
                    sel ? (len + 3) / 4 + 1 : len + 1, 1'b0,
                    $sformatf("rand%0d/bpc%0d m%0b d%06h", i, sel ? 4 : 1, m, d));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
